rtc_bus_writer: RTL

- Responder side of the register-write handshake (escribe / dir / dato / fin) issued by the user-time machine.
- Converts one write request into a timed write cycle on the RTC multiplexed address/data parallel bus: address phase, then data phase, each with setup, strobe and hold.
- Pulses fin when the bus cycle completes.
- Sits between the user/initialisation machines and the RTC chip pins.

---
 rtl/rtc_bus_writer_if.sv | 53 +++++
 rtl/rtc_bus_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_writer_if.sv
// -----------------------------------------------------------------------------
// rtc_bus_writer_if
//
// Purpose:
//   Groups the register-write handshake (escribe / dir_in / dato_in / fin) and
//   the RTC multiplexed address/data bus pins into one bundle.
//
// Signals:
//   escribe   write request, level
//   dir_in    RTC register address (8 bits)
//   dato_in   data to write (8 bits)
//   ad_in     bus read-back value (8 bits)
//   fin       one-cycle completion pulse
//   busy      writer is not idle
//   err       read-back mismatch, valid while fin=1
//   ad_out    bus address/data value (8 bits)
//   ad_oe     tristate enable for ad_out
//   cs_n      chip select, active low
//   wr_n      write strobe, active low
//   rd_n      read strobe, active low
//   a_d       0 = address phase, 1 = data phase
//
// Modports:
//   slave   the bus writer (answers requests, drives the RTC pins)
//   master  the requester / RTC pin environment
// -----------------------------------------------------------------------------
interface rtc_bus_writer_if;

  logic       escribe;
  logic [7:0] dir_in;
  logic [7:0] dato_in;
  logic [7:0] ad_in;
  logic       fin;
  logic       busy;
  logic       err;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       a_d;

  modport slave (
    input  escribe, dir_in, dato_in, ad_in,
    output fin, busy, err, ad_out, ad_oe, cs_n, wr_n, rd_n, a_d
  );

  modport master (
    output escribe, dir_in, dato_in, ad_in,
    input  fin, busy, err, ad_out, ad_oe, cs_n, wr_n, rd_n, a_d
  );

endinterface

// File: rtl/rtc_bus_writer.sv
// -----------------------------------------------------------------------------
// rtc_bus_writer
//
// Purpose:
//   Responder side of the register-write handshake. One accepted request
//   becomes one timed write cycle on the RTC multiplexed address/data bus:
//   an address phase followed by a data phase, each made of setup, strobe and
//   hold sub-phases. fin pulses for one cycle when the bus cycle completes,
//   after which the block waits for escribe to drop before accepting again.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-low reset
//   rtc     rtc_bus_writer_if.slave: handshake (escribe, dir_in, dato_in,
//           fin, busy, err) and RTC pins (ad_out, ad_oe, cs_n, wr_n, rd_n,
//           a_d, ad_in)
//
// Parameters:
//   T_SETUP  cycles the bus is stable before the strobe falls (min 1)
//   T_PULSE  cycles the strobe is held low (min 1)
//   T_HOLD   cycles after the strobe rises before the next phase (min 1)
//
// Build option:
//   RTC_READBACK_EN  when defined, the write is followed by a repeated address
//                    phase and a read phase; err flags a read-back mismatch.
//                    When undefined, rd_n is constant 1, err is constant 0 and
//                    ad_in is ignored.
//
// All outputs are registered: they are decoded from the current state and
// appear one cycle after the state is entered, so every phase keeps its exact
// length on the pins.
// -----------------------------------------------------------------------------
module rtc_bus_writer #(
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_PULSE = 8,
  parameter int unsigned T_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  rtc_bus_writer_if.slave   rtc
);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] CNT_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] CNT_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] CNT_HOLD  = 8'(T_HOLD - 1);

  typedef enum logic [3:0] {
    IDLE,
    A_SU,
    A_WR,
    A_HD,
    D_SU,
    D_WR,
    D_HD,
`ifdef RTC_READBACK_EN
    RA_SU,
    RA_WR,
    RA_HD,
    R_SU,
    R_RD,
    R_HD,
`endif
    DONE,
    WAIT_LOW
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic       cnt_zero;

  // Request captured at acceptance; the inputs are ignored afterwards.
  logic [7:0] addr_q;
  logic [7:0] data_q;

  // Registered outputs and their next values.
  logic       cs_n_q,   cs_n_nx;
  logic       wr_n_q,   wr_n_nx;
  logic       a_d_q,    a_d_nx;
  logic       ad_oe_q,  ad_oe_nx;
  logic [7:0] ad_out_q, ad_out_nx;
  logic       fin_q,    fin_nx;
  logic       busy_q,   busy_nx;

  logic       addr_ph;
  logic       data_ph;

`ifdef RTC_READBACK_EN
  logic       rd_n_q,   rd_n_nx;
  logic       err_q,    err_nx;
  logic [7:0] sample_q;
  logic       read_ph;
`endif

  // Length of the phase that a state represents, as a counter reload value.
  function automatic logic [7:0] phase_len(input state_t s);
    logic [7:0] len;
    len = 8'd0;
    unique case (s)
      A_SU, D_SU: len = CNT_SETUP;
      A_WR, D_WR: len = CNT_PULSE;
      A_HD, D_HD: len = CNT_HOLD;
`ifdef RTC_READBACK_EN
      RA_SU, R_SU: len = CNT_SETUP;
      RA_WR, R_RD: len = CNT_PULSE;
      RA_HD, R_HD: len = CNT_HOLD;
`endif
      default:    len = 8'd0;
    endcase
    return len;
  endfunction

  assign cnt_zero = (cnt == 8'd0);

  // ---------------------------------------------------------------------------
  // Next state and next output values
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_nx  = state;
    cs_n_nx   = 1'b1;
    wr_n_nx   = 1'b1;
    a_d_nx    = 1'b1;
    ad_oe_nx  = 1'b0;
    ad_out_nx = 8'h00;
    fin_nx    = 1'b0;
    busy_nx   = (state != IDLE);
    addr_ph   = 1'b0;
    data_ph   = 1'b0;
`ifdef RTC_READBACK_EN
    rd_n_nx   = 1'b1;
    err_nx    = 1'b0;
    read_ph   = 1'b0;
`endif

    unique case (state)
      IDLE:     if (rtc.escribe) state_nx = A_SU;
      A_SU:     if (cnt_zero) state_nx = A_WR;
      A_WR:     if (cnt_zero) state_nx = A_HD;
      A_HD:     if (cnt_zero) state_nx = D_SU;
      D_SU:     if (cnt_zero) state_nx = D_WR;
      D_WR:     if (cnt_zero) state_nx = D_HD;
`ifdef RTC_READBACK_EN
      D_HD:     if (cnt_zero) state_nx = RA_SU;
      RA_SU:    if (cnt_zero) state_nx = RA_WR;
      RA_WR:    if (cnt_zero) state_nx = RA_HD;
      RA_HD:    if (cnt_zero) state_nx = R_SU;
      R_SU:     if (cnt_zero) state_nx = R_RD;
      R_RD:     if (cnt_zero) state_nx = R_HD;
      R_HD:     if (cnt_zero) state_nx = DONE;
`else
      D_HD:     if (cnt_zero) state_nx = DONE;
`endif
      DONE:     state_nx = WAIT_LOW;
      // A request held high past fin must not start a second bus cycle.
      WAIT_LOW: if (!rtc.escribe) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase

    // Output decode from the current state.
    addr_ph = (state == A_SU) || (state == A_WR) || (state == A_HD);
    data_ph = (state == D_SU) || (state == D_WR) || (state == D_HD);
`ifdef RTC_READBACK_EN
    addr_ph = addr_ph || (state == RA_SU) || (state == RA_WR) || (state == RA_HD);
    read_ph = (state == R_SU) || (state == R_RD) || (state == R_HD);
`endif

    if (addr_ph || data_ph) begin
      cs_n_nx   = 1'b0;
      ad_oe_nx  = 1'b1;
      a_d_nx    = data_ph;
      ad_out_nx = data_ph ? data_q : addr_q;
    end

    wr_n_nx = !((state == A_WR) || (state == D_WR));
`ifdef RTC_READBACK_EN
    wr_n_nx = wr_n_nx && (state != RA_WR);
    // Read phase: chip selected, bus released, a_d left at 1.
    if (read_ph) cs_n_nx = 1'b0;
    rd_n_nx = (state != R_RD);
    if (state == DONE) err_nx = (sample_q != data_q);
`endif

    fin_nx = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // State, phase counter, request latch and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'h00;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples the pre-edge values regardless of statement order.
      state <= state_nx;
      // Reload on every state entry; otherwise count down to zero.
      if (state_nx != state) begin
        cnt <= phase_len(state_nx);
      end else if (!cnt_zero) begin
        cnt <= cnt - 8'd1;
      end
      if ((state == IDLE) && rtc.escribe) begin
        addr_q <= rtc.dir_in;
        data_q <= rtc.dato_in;
      end
      cs_n_q   <= cs_n_nx;
      wr_n_q   <= wr_n_nx;
      a_d_q    <= a_d_nx;
      ad_oe_q  <= ad_oe_nx;
      ad_out_q <= ad_out_nx;
      fin_q    <= fin_nx;
      busy_q   <= busy_nx;
    end
  end

`ifdef RTC_READBACK_EN
  // Read-back path. ad_in is captured on every cycle the read strobe is low on
  // the pin, so the value kept is the one from the last strobe cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_n_q   <= 1'b1;
      err_q    <= 1'b0;
      sample_q <= 8'h00;
    end else begin
      rd_n_q <= rd_n_nx;
      err_q  <= err_nx;
      if (!rd_n_q) sample_q <= rtc.ad_in;
    end
  end

  assign rtc.rd_n = rd_n_q;
  assign rtc.err  = err_q;
`else
  // Without read-back the read strobe and error flag are tied off and the
  // bus read-back value has no destination.
  logic unused_ad_in;
  assign unused_ad_in = ^rtc.ad_in;

  assign rtc.rd_n = 1'b1;
  assign rtc.err  = 1'b0;
`endif

  assign rtc.cs_n   = cs_n_q;
  assign rtc.wr_n   = wr_n_q;
  assign rtc.a_d    = a_d_q;
  assign rtc.ad_oe  = ad_oe_q;
  assign rtc.ad_out = ad_out_q;
  assign rtc.fin    = fin_q;
  assign rtc.busy   = busy_q;

endmodule
